module_captura_operandos: RTL
=============================

Name: module_captura_operandos

Overview:
- Consumer side of the keypad key-event interface; sits after the keypad decoder.
- Takes one event per rising edge of data_available with its 4-bit key code.
- Assembles decimal digits into two operands, A then B, and presents them with a valid/ready handshake to the multiplier datapath.
- Exposes the digits being entered, in BCD, for display.

Parameters:
- MAX_DIGITS, 2, maximum decimal digits per operand.
- OP_W, 8, binary operand width; must satisfy 2^OP_W > 10^MAX_DIGITS - 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- data_available  input  1  level from debounce; high while a key is held; synchronous to clk.
- dato_i  input  4  key code; stable whenever data_available is high.
- op_ready  input  1  multiplier accepts operands.
- op_a  output  OP_W  operand A, binary.
- op_b  output  OP_W  operand B, binary.
- op_valid  output  1  operands complete and stable.
- entry_bcd  output  4*MAX_DIGITS  digits of the operand being entered; least significant digit in bits [3:0].
- state_o  output  2  current state encoding, for display.

Behaviour:
- Reset (rst=0, asynchronous):
  - op_a=0, op_b=0, op_valid=0, entry_bcd=0, state_o=CAPT_A (2'b00).
  - Digit count=0; edge-detect register=0.
  - Reset asserted mid-entry or while in DONE discards everything.
- Key event:
  - Fires on the cycle where data_available=1 and its registered copy is 0.
  - Exactly one event per press, however long the key is held.
  - Events take effect on the next clk edge (1-cycle latency).
- Key classes:
  - 0x0-0x9: digit.
  - 0xA: ENTER.
  - 0xB: CLEAR.
  - 0xC: ABORT.
  - 0xD-0xF: ignored, no state change.
- States: CAPT_A=00, CAPT_B=01, DONE=10. Encoding 11 is unreachable; if reached, return to CAPT_A.
- Digit in CAPT_A or CAPT_B:
  - If count < MAX_DIGITS: entry_bcd <= {entry_bcd, digit} truncated to width (shift left by 4); count+1.
  - If count == MAX_DIGITS: the digit is ignored.
  - Leading zeros count as digits.
- ENTER:
  - With count=0: ignored.
  - In CAPT_A: op_a <= binary(entry_bcd); entry_bcd <= 0; count <= 0; go to CAPT_B.
  - In CAPT_B: op_b <= binary(entry_bcd); clear entry; go to DONE; op_valid=1 from that edge.
- CLEAR in CAPT_A/CAPT_B: entry_bcd=0, count=0, state unchanged (base behaviour).
- ABORT, any state: op_a=0, op_b=0, entry=0, count=0, op_valid=0, go to CAPT_A.
- DONE:
  - op_a, op_b and op_valid are held stable.
  - Digit, ENTER and CLEAR are ignored.
  - When op_valid=1 and op_ready=1 on a clk edge: op_valid <= 0, go to CAPT_A. op_a/op_b keep their values until overwritten.
  - op_ready while not in DONE has no effect.
- Simultaneous events:
  - op_ready handshake and an ABORT event in the same cycle: handshake completes (op_valid <= 0), and op_a and op_b are still zeroed.
  - op_ready handshake and a digit event in the same cycle: handshake completes; the digit is dropped.
- Binary conversion:
  - sum over i of digit_i * 10^i, computed combinationally at ENTER.
  - Zero-extended to OP_W; no overflow by parameter rule.

Optional Feature:
- Macro: CAPTURA_BACKSPACE_EN.
- Defined:
  - CLEAR (0xB) with count>0 removes only the last digit: entry_bcd <= entry_bcd >> 4; count-1.
  - CLEAR with count=0 is ignored.
- Undefined: CLEAR zeroes the entire entry (base behaviour).

Decomposition:
- Package pkg_captura:
  - State enum state_t {CAPT_A, CAPT_B, DONE}.
  - Key constants KEY_ENTER=4'hA, KEY_CLR=4'hB, KEY_ABORT=4'hC.
  - Function is_digit().
- One sub-module: module_bcd2bin.
  - Combinational, parameterised by MAX_DIGITS/OP_W.
  - Instantiated once on entry_bcd.
  - Result is registered into op_a/op_b by the parent FSM.

Test Plan:
- Keys 4,2,A,1,5,A (data_available held 50 cycles per press, 20 cycles low between presses) -> op_a=42, op_b=15, op_valid=1, state_o=10; op_ready pulse for 1 cycle -> op_valid=0, state_o=00.
- Keys 9,9,9,A with MAX_DIGITS=2 -> third digit ignored, op_a=99; ENTER with no digits -> state_o stays 01.
- Keys 3,7,B,5,A:
  - macro undefined -> op_a=5.
  - CAPTURA_BACKSPACE_EN -> op_a=35.
- In DONE with A=12, B=34: press 6 and ENTER -> op_a/op_b unchanged, op_valid=1; press C -> op_valid=0, op_a=op_b=0, state_o=00.
- Key 0xE in CAPT_A after digit 8 -> entry_bcd=0x08 unchanged; then ENTER -> op_a=8.
- Assert rst=0 asynchronously (between clk edges) mid-entry after 1,2 -> all outputs zero immediately; after release, keys 7,A,0,A -> op_a=7, op_b=0, op_valid=1.

Source files
------------

// File: rtl/module_captura_operandos_pkg.sv
// Shared types and key codes for the keypad operand-capture block.
package pkg_captura;

    typedef enum logic [1:0] {
        CAPT_A = 2'b00,
        CAPT_B = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_ABORT = 4'hC;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage

// File: rtl/module_captura_operandos_bcd2bin.sv
// Combinational packed-BCD to binary converter; least significant digit in bits [3:0].
module module_bcd2bin #(
    parameter int MAX_DIGITS = 2,
    parameter int OP_W       = 8
) (
    input  logic [4*MAX_DIGITS-1:0] bcd_i,
    output logic [OP_W-1:0]         bin_o
);

    logic [OP_W-1:0] acc;
    logic [OP_W-1:0] weight;

    // Weight past the top digit may wrap; it is never used.
    always_comb begin
        acc    = '0;
        weight = OP_W'(1);
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            acc    = acc + OP_W'(bcd_i[4*i +: 4]) * weight;
            weight = weight * OP_W'(10);
        end
        bin_o = acc;
    end

endmodule

// File: rtl/module_captura_operandos.sv
// Keypad operand capture: builds operands A and B from decimal key events.
// Optional macro CAPTURA_BACKSPACE_EN turns CLEAR into a single-digit backspace.
module module_captura_operandos
    import pkg_captura::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int OP_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_available,
    input  logic [3:0]              dato_i,
    input  logic                    op_ready,
    output logic [OP_W-1:0]         op_a,
    output logic [OP_W-1:0]         op_b,
    output logic                    op_valid,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [1:0]              state_o
);

    localparam int ENTRY_W = 4 * MAX_DIGITS;
    localparam int CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

    state_t              state_q, state_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [CW-1:0]       count_q, count_d;
    logic [OP_W-1:0]     op_a_q, op_a_d;
    logic [OP_W-1:0]     op_b_q, op_b_d;
    logic                op_valid_q, op_valid_d;
    logic                da_q, da_d;
    logic                key_evt;
    logic [OP_W-1:0]     entry_bin;

    module_bcd2bin #(
        .MAX_DIGITS (MAX_DIGITS),
        .OP_W       (OP_W)
    ) u_bcd2bin (
        .bcd_i (entry_q),
        .bin_o (entry_bin)
    );

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        count_d    = count_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        da_d       = data_available;
        key_evt    = data_available & ~da_q;

        case (state_q)
            CAPT_A, CAPT_B: begin
                if (key_evt) begin
                    if (is_digit(dato_i)) begin
                        if (count_q < CNT_MAX) begin
                            entry_d = (entry_q << 4) | ENTRY_W'(dato_i);
                            count_d = count_q + 1'b1;
                        end
                    end else if (dato_i == KEY_ENTER) begin
                        if (count_q != '0) begin
                            if (state_q == CAPT_A) begin
                                op_a_d  = entry_bin;
                                state_d = CAPT_B;
                            end else begin
                                op_b_d     = entry_bin;
                                op_valid_d = 1'b1;
                                state_d    = DONE;
                            end
                            entry_d = '0;
                            count_d = '0;
                        end
                    end else if (dato_i == KEY_CLR) begin
`ifdef CAPTURA_BACKSPACE_EN
                        if (count_q != '0) begin
                            entry_d = entry_q >> 4;
                            count_d = count_q - 1'b1;
                        end
`else
                        entry_d = '0;
                        count_d = '0;
`endif
                    end else if (dato_i == KEY_ABORT) begin
                        op_a_d     = '0;
                        op_b_d     = '0;
                        entry_d    = '0;
                        count_d    = '0;
                        op_valid_d = 1'b0;
                        state_d    = CAPT_A;
                    end
                end
            end
            DONE: begin
                if (op_valid_q && op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = CAPT_A;
                end
                // ABORT may coincide with the handshake; both take effect.
                if (key_evt && (dato_i == KEY_ABORT)) begin
                    op_a_d     = '0;
                    op_b_d     = '0;
                    entry_d    = '0;
                    count_d    = '0;
                    op_valid_d = 1'b0;
                    state_d    = CAPT_A;
                end
            end
            default: begin
                state_d = CAPT_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CAPT_A;
            entry_q    <= '0;
            count_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            da_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            count_q    <= count_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            da_q       <= da_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign entry_bcd = entry_q;
    assign state_o   = state_q;

endmodule
